alu_issue_queue: RTL and testbench
==================================

Name: alu_issue_queue

Overview:
- Parametrised issue queue (reservation station) between dispatch/rename and the ALUMISC functional unit.
- Holds up to DEPTH in-flight ALU ops, captures operands from the writeback broadcast (tag wakeup) and issues the oldest ready op per cycle to the ALU.
- Replaces the single-slot issue register feeding iss_a0_* with a multi-entry, age-ordered, flushable buffer.

Parameters:
DEPTH, 4, number of entries (2..16)
DATA_W, 32, operand width
TAG_W, 6, physical tag width
ALUOP_W, 4, ALU opcode width

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-low reset
flush  in  1  synchronous flush; discards all entries
disp_valid  in  1  dispatch request
disp_ready  out  1  queue can accept an op
disp_aluop  in  ALUOP_W  op code
disp_dest_tag  in  TAG_W  result tag
disp_a_tag / disp_b_tag  in  TAG_W  source tags
disp_a_rdy / disp_b_rdy  in  1  source value already valid
disp_a_val / disp_b_val  in  DATA_W  source values (meaningful when rdy=1)
wb_valid  in  1  writeback broadcast valid
wb_tag  in  TAG_W  writeback tag
wb_data  in  DATA_W  writeback value
iss_valid  out  1  an op is offered to the ALU
iss_ready  in  1  ALU accepts the op
iss_aluop  out  ALUOP_W  issued op code
iss_rega / iss_regb  out  DATA_W  issued operands
iss_dest_tag  out  TAG_W  issued result tag
count  out  $clog2(DEPTH+1)  occupied entries

Behaviour:
- Reset (reset=0, async): all entries invalid. count=0, iss_valid=0, disp_ready=1. All iss_* data outputs are 0.
- Storage is a collapsing queue: entry 0 is the oldest. Removing an entry shifts all younger entries down by one in the same edge.
- disp_ready = (count < DEPTH). It does not depend on an issue in the same cycle.
- Dispatch fires when disp_valid && disp_ready. The new entry is written at index count, or count-1 if an issue fires the same edge.
- Select (combinational): iss_valid=1 when any valid entry has both operands ready. The lowest-index such entry drives iss_*. Selection uses registered ready bits only.
- Issue fires when iss_valid && iss_ready. The selected entry is removed on that edge. iss_* are stable while iss_valid && !iss_ready, unless an older entry becomes ready, in which case the older entry is selected next cycle.
- Wakeup: on wb_valid, every valid entry with a non-ready source whose tag equals wb_tag latches wb_data and sets ready at the edge. Both sources of one entry may wake together.
- Dispatch/wakeup collision: a dispatching op whose non-ready source tag equals wb_tag in the same cycle is written ready with wb_data. No lost wakeup.
- Latency: an op dispatched fully ready is offered at iss_valid the cycle after dispatch. An op woken at edge N is offered from cycle N+1.
- count updates as +1 on dispatch, -1 on issue, unchanged when both or neither fire.
- flush=1 at an edge: all entries invalid, count=0. Flush dominates a same-cycle dispatch, issue and wakeup; none of them take effect.
- Full queue with a simultaneous issue: dispatch is still refused that cycle (disp_ready=0).

Test Plan:
- Reset, then dispatch addi (aluop ADD, a=5 rdy, b=7 rdy, dest 10) -> next cycle iss_valid=1, iss_rega=5, iss_regb=7, iss_dest_tag=10. iss_ready=1 -> count returns to 0.
- Dependency: dispatch add dest 12, a_tag 10 not ready, b=8 ready. wb_valid tag 10 data 12 at edge N -> iss_valid rises cycle N+1 with rega=12, regb=8.
- Same-cycle bypass: dispatch with a_tag 11 not ready while wb_tag=11 data 15 -> entry ready. Next cycle iss_rega=15.
- Age order: fill DEPTH=4 entries, with entry 2 ready first and then entry 0 woken -> entry 2 issues first, then entry 0. Remaining order preserved. disp_ready=0 at count=4.
- Backpressure: iss_ready=0 for 3 cycles with one ready entry -> iss_* stable, count unchanged.
- Flush mid-operation with 3 entries plus a dispatch and wakeup in the same cycle -> count=0 and iss_valid=0 next cycle. Async reset asserted mid-cycle clears outputs immediately.

Source files
------------

// File: rtl/alu_issue_queue_if.sv
// Dispatch, writeback-broadcast and issue signal bundle for the ALU issue queue.
// master = surrounding pipeline (dispatch/writeback/ALU); slave = the queue itself.
interface alu_issue_queue_if #(
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int ALUOP_W = 4
);
  logic               disp_valid;
  logic               disp_ready;
  logic [ALUOP_W-1:0] disp_aluop;
  logic [TAG_W-1:0]   disp_dest_tag;
  logic [TAG_W-1:0]   disp_a_tag;
  logic [TAG_W-1:0]   disp_b_tag;
  logic               disp_a_rdy;
  logic               disp_b_rdy;
  logic [DATA_W-1:0]  disp_a_val;
  logic [DATA_W-1:0]  disp_b_val;

  logic               wb_valid;
  logic [TAG_W-1:0]   wb_tag;
  logic [DATA_W-1:0]  wb_data;

  logic               iss_valid;
  logic               iss_ready;
  logic [ALUOP_W-1:0] iss_aluop;
  logic [DATA_W-1:0]  iss_rega;
  logic [DATA_W-1:0]  iss_regb;
  logic [TAG_W-1:0]   iss_dest_tag;

  modport master (
    output disp_valid, disp_aluop, disp_dest_tag, disp_a_tag, disp_b_tag,
           disp_a_rdy, disp_b_rdy, disp_a_val, disp_b_val,
           wb_valid, wb_tag, wb_data, iss_ready,
    input  disp_ready, iss_valid, iss_aluop, iss_rega, iss_regb, iss_dest_tag
  );

  modport slave (
    input  disp_valid, disp_aluop, disp_dest_tag, disp_a_tag, disp_b_tag,
           disp_a_rdy, disp_b_rdy, disp_a_val, disp_b_val,
           wb_valid, wb_tag, wb_data, iss_ready,
    output disp_ready, iss_valid, iss_aluop, iss_rega, iss_regb, iss_dest_tag
  );
endinterface

// File: rtl/alu_issue_queue.sv
// Age-ordered collapsing issue queue for the ALUMISC unit: captures operands by
// tag wakeup from the writeback bus and offers the oldest ready op each cycle.
module alu_issue_queue #(
  parameter int DEPTH   = 4,
  parameter int DATA_W  = 32,
  parameter int TAG_W   = 6,
  parameter int ALUOP_W = 4
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         flush,
  alu_issue_queue_if.slave             q,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int CW = $clog2(DEPTH+1);

  typedef struct packed {
    logic [ALUOP_W-1:0] aluop;
    logic [TAG_W-1:0]   dest;
    logic [TAG_W-1:0]   a_tag;
    logic [TAG_W-1:0]   b_tag;
    logic               a_rdy;
    logic               b_rdy;
    logic [DATA_W-1:0]  a_val;
    logic [DATA_W-1:0]  b_val;
  } entry_t;

  entry_t          ent_r [DEPTH];
  entry_t          ent_n [DEPTH];
  entry_t          woke  [DEPTH];
  entry_t          new_ent;
  entry_t          sel_ent;
  logic [CW-1:0]   cnt_r;
  logic [CW-1:0]   cnt_n;
  logic [CW-1:0]   sel_idx;
  logic [CW-1:0]   wr_idx;
  logic [DEPTH-1:0] vld;
  logic            found;
  logic            disp_fire;
  logic            iss_fire;

  // Entries 0..count-1 are occupied; the queue never has holes.
  always_comb begin
    vld = '0;
    for (int unsigned i = 0; i < DEPTH; i++)
      vld[i] = (i < 32'(cnt_r));
  end

  // Oldest-ready select from registered ready bits only.
  always_comb begin
    found   = 1'b0;
    sel_idx = '0;
    sel_ent = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && vld[i] && ent_r[i].a_rdy && ent_r[i].b_rdy) begin
        found   = 1'b1;
        sel_idx = CW'(i);
        sel_ent = ent_r[i];
      end
    end
  end

  assign q.disp_ready   = (cnt_r < CW'(DEPTH));
  assign q.iss_valid    = found;
  assign q.iss_aluop    = sel_ent.aluop;
  assign q.iss_rega     = sel_ent.a_val;
  assign q.iss_regb     = sel_ent.b_val;
  assign q.iss_dest_tag = sel_ent.dest;
  assign count          = cnt_r;

  assign disp_fire = q.disp_valid && q.disp_ready;
  assign iss_fire  = found && q.iss_ready;

  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i] = ent_r[i];
      if (q.wb_valid && vld[i]) begin
        if (!woke[i].a_rdy && woke[i].a_tag == q.wb_tag) begin
          woke[i].a_rdy = 1'b1;
          woke[i].a_val = q.wb_data;
        end
        if (!woke[i].b_rdy && woke[i].b_tag == q.wb_tag) begin
          woke[i].b_rdy = 1'b1;
          woke[i].b_val = q.wb_data;
        end
      end
    end

    // Incoming op sees the same-cycle broadcast so its wakeup is not lost.
    new_ent.aluop = q.disp_aluop;
    new_ent.dest  = q.disp_dest_tag;
    new_ent.a_tag = q.disp_a_tag;
    new_ent.b_tag = q.disp_b_tag;
    new_ent.a_rdy = q.disp_a_rdy;
    new_ent.b_rdy = q.disp_b_rdy;
    new_ent.a_val = q.disp_a_val;
    new_ent.b_val = q.disp_b_val;
    if (q.wb_valid && !q.disp_a_rdy && q.disp_a_tag == q.wb_tag) begin
      new_ent.a_rdy = 1'b1;
      new_ent.a_val = q.wb_data;
    end
    if (q.wb_valid && !q.disp_b_rdy && q.disp_b_tag == q.wb_tag) begin
      new_ent.b_rdy = 1'b1;
      new_ent.b_val = q.wb_data;
    end

    // Collapse over the issued slot, then append behind the survivors.
    for (int unsigned i = 0; i < DEPTH - 1; i++)
      ent_n[i] = (iss_fire && CW'(i) >= sel_idx) ? woke[i+1] : woke[i];
    ent_n[DEPTH-1] = woke[DEPTH-1];

    wr_idx = iss_fire ? (cnt_r - CW'(1)) : cnt_r;
    for (int unsigned i = 0; i < DEPTH; i++)
      if (disp_fire && CW'(i) == wr_idx)
        ent_n[i] = new_ent;

    cnt_n = cnt_r;
    case ({disp_fire, iss_fire})
      2'b10:   cnt_n = cnt_r + CW'(1);
      2'b01:   cnt_n = cnt_r - CW'(1);
      default: cnt_n = cnt_r;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_r <= '0;
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_r[i] <= '0;
    end else if (flush) begin
      cnt_r <= '0;
    end else begin
      cnt_r <= cnt_n;
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_r[i] <= ent_n[i];
    end
  end

endmodule

// File: tb/tb_alu_issue_queue.sv
// Directed bench for alu_issue_queue (DEPTH=4): issue latency, wakeup, bypass,
// age order, backpressure, flush and asynchronous reset.
module tb_alu_issue_queue;

  localparam int DEPTH   = 4;
  localparam int DATA_W  = 32;
  localparam int TAG_W   = 6;
  localparam int ALUOP_W = 4;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [2:0] count;
  int         n_cmp;
  int         n_err;

  alu_issue_queue_if #(.DATA_W(DATA_W), .TAG_W(TAG_W), .ALUOP_W(ALUOP_W)) bus ();

  alu_issue_queue #(.DEPTH(DEPTH), .DATA_W(DATA_W), .TAG_W(TAG_W), .ALUOP_W(ALUOP_W)) dut (
    .clock (clk),
    .reset (rst_n),
    .flush (flush),
    .q     (bus.slave),
    .count (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic disp(input logic [3:0] op, input logic [5:0] dest,
                      input logic [5:0] at, input logic ar, input logic [31:0] av,
                      input logic [5:0] bt, input logic br, input logic [31:0] bv);
    bus.disp_valid    = 1'b1;
    bus.disp_aluop    = op;
    bus.disp_dest_tag = dest;
    bus.disp_a_tag    = at;
    bus.disp_a_rdy    = ar;
    bus.disp_a_val    = av;
    bus.disp_b_tag    = bt;
    bus.disp_b_rdy    = br;
    bus.disp_b_val    = bv;
  endtask

  task automatic wb(input logic [5:0] t, input logic [31:0] d);
    bus.wb_valid = 1'b1;
    bus.wb_tag   = t;
    bus.wb_data  = d;
  endtask

  task automatic idle();
    bus.disp_valid = 1'b0;
    bus.wb_valid   = 1'b0;
    bus.iss_ready  = 1'b0;
    flush          = 1'b0;
  endtask

  task automatic chk_iss(input string tag, input logic [5:0] dest,
                         input logic [31:0] a, input logic [31:0] b);
    chk({tag, "_valid"}, 64'(bus.iss_valid), 64'(1));
    chk({tag, "_dest"},  64'(bus.iss_dest_tag), 64'(dest));
    chk({tag, "_rega"},  64'(bus.iss_rega), 64'(a));
    chk({tag, "_regb"},  64'(bus.iss_regb), 64'(b));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    disp(4'd0, 6'd0, 6'd0, 1'b0, 32'd0, 6'd0, 1'b0, 32'd0);
    bus.wb_tag  = '0;
    bus.wb_data = '0;
    idle();
    @(negedge clk);
    @(negedge clk);
    chk("rst_count", 64'(count), 64'(0));
    chk("rst_iss_valid", 64'(bus.iss_valid), 64'(0));
    chk("rst_disp_ready", 64'(bus.disp_ready), 64'(1));
    chk("rst_iss_rega", 64'(bus.iss_rega), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);

    // Fully ready op is offered the cycle after dispatch.
    disp(4'd1, 6'd10, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7);
    chk("addi_pre_valid", 64'(bus.iss_valid), 64'(0));
    tick();
    idle();
    chk_iss("addi", 6'd10, 32'd5, 32'd7);
    chk("addi_aluop", 64'(bus.iss_aluop), 64'(1));
    chk("addi_count", 64'(count), 64'(1));
    bus.iss_ready = 1'b1;
    tick();
    idle();
    chk("addi_count_after", 64'(count), 64'(0));
    chk("addi_valid_after", 64'(bus.iss_valid), 64'(0));

    // Dependency on tag 10.
    disp(4'd1, 6'd12, 6'd10, 1'b0, 32'd0, 6'd3, 1'b1, 32'd8);
    tick();
    idle();
    chk("dep_wait_valid", 64'(bus.iss_valid), 64'(0));
    chk("dep_count", 64'(count), 64'(1));
    wb(6'd10, 32'd12);
    tick();
    idle();
    chk_iss("dep", 6'd12, 32'd12, 32'd8);
    bus.iss_ready = 1'b1;
    tick();
    idle();
    chk("dep_count_after", 64'(count), 64'(0));

    // Same-cycle dispatch/wakeup bypass.
    disp(4'd2, 6'd13, 6'd11, 1'b0, 32'd0, 6'd4, 1'b1, 32'd3);
    wb(6'd11, 32'd15);
    tick();
    idle();
    chk_iss("bypass", 6'd13, 32'd15, 32'd3);
    bus.iss_ready = 1'b1;
    tick();
    idle();
    chk("bypass_count_after", 64'(count), 64'(0));

    // Dispatch and issue on the same edge: new op lands at count-1.
    disp(4'd3, 6'd14, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd2);
    tick();
    idle();
    chk_iss("x", 6'd14, 32'd1, 32'd2);
    bus.iss_ready = 1'b1;
    disp(4'd3, 6'd15, 6'd0, 1'b1, 32'd3, 6'd0, 1'b1, 32'd4);
    tick();
    idle();
    chk("di_count", 64'(count), 64'(1));
    chk_iss("y", 6'd15, 32'd3, 32'd4);
    bus.iss_ready = 1'b1;
    tick();
    idle();
    chk("di_count_after", 64'(count), 64'(0));

    // Both sources of one entry wake from a single broadcast.
    disp(4'd4, 6'd16, 6'd40, 1'b0, 32'd0, 6'd40, 1'b0, 32'd0);
    tick();
    idle();
    wb(6'd40, 32'h44);
    tick();
    idle();
    chk_iss("dual", 6'd16, 32'h44, 32'h44);
    bus.iss_ready = 1'b1;
    tick();
    idle();

    // Fill the queue with four waiting ops (dest 20..23, a_tag 30..33).
    for (int i = 0; i < 4; i++) begin
      disp(4'd5, 6'(20 + i), 6'(30 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'(i + 1));
      tick();
    end
    idle();
    chk("full_count", 64'(count), 64'(4));
    chk("full_disp_ready", 64'(bus.disp_ready), 64'(0));
    chk("full_valid", 64'(bus.iss_valid), 64'(0));

    wb(6'd32, 32'h32);
    tick();
    idle();
    chk_iss("e2", 6'd22, 32'h32, 32'd3);

    for (int i = 0; i < 3; i++) begin
      tick();
      chk_iss("bp", 6'd22, 32'h32, 32'd3);
      chk("bp_count", 64'(count), 64'(4));
    end

    // Issue while full: the offered dispatch must still be refused.
    bus.iss_ready = 1'b1;
    disp(4'd6, 6'd24, 6'd0, 1'b1, 32'd9, 6'd0, 1'b1, 32'd9);
    chk("full_iss_disp_ready", 64'(bus.disp_ready), 64'(0));
    tick();
    idle();
    chk("after_e2_count", 64'(count), 64'(3));
    chk("after_e2_valid", 64'(bus.iss_valid), 64'(0));

    wb(6'd30, 32'h30);
    tick();
    idle();
    chk_iss("e0", 6'd20, 32'h30, 32'd1);
    bus.iss_ready = 1'b1;
    tick();
    idle();
    chk("after_e0_count", 64'(count), 64'(2));

    wb(6'd33, 32'h33);
    tick();
    idle();
    chk_iss("e3_first", 6'd23, 32'h33, 32'd4);
    wb(6'd31, 32'h31);
    tick();
    idle();
    chk_iss("e1_older", 6'd21, 32'h31, 32'd2);
    bus.iss_ready = 1'b1;
    tick();
    chk_iss("e3_next", 6'd23, 32'h33, 32'd4);
    chk("after_e1_count", 64'(count), 64'(1));
    tick();
    idle();
    chk("drain_count", 64'(count), 64'(0));

    // Flush dominates same-cycle dispatch, issue and wakeup.
    disp(4'd7, 6'd50, 6'd0, 1'b1, 32'd1, 6'd0, 1'b1, 32'd1);
    tick();
    disp(4'd7, 6'd51, 6'd61, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
    tick();
    disp(4'd7, 6'd52, 6'd62, 1'b0, 32'd0, 6'd0, 1'b1, 32'd1);
    tick();
    idle();
    chk("pre_flush_count", 64'(count), 64'(3));
    flush = 1'b1;
    bus.iss_ready = 1'b1;
    disp(4'd7, 6'd53, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2);
    wb(6'd61, 32'h61);
    tick();
    idle();
    chk("flush_count", 64'(count), 64'(0));
    chk("flush_valid", 64'(bus.iss_valid), 64'(0));
    tick();
    chk("flush_valid_later", 64'(bus.iss_valid), 64'(0));

    // Asynchronous reset mid-cycle clears outputs without a clock edge.
    disp(4'd8, 6'd55, 6'd0, 1'b1, 32'hAB, 6'd0, 1'b1, 32'hCD);
    tick();
    idle();
    chk_iss("pre_arst", 6'd55, 32'hAB, 32'hCD);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(bus.iss_valid), 64'(0));
    chk("arst_count", 64'(count), 64'(0));
    chk("arst_rega", 64'(bus.iss_rega), 64'(0));
    chk("arst_disp_ready", 64'(bus.disp_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
